seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the lab's 32-bit combinational ALU, with the same opcode family and zero/ovf/carry flags.
- Operands enter through a valid/ready input handshake; results and flags leave through a registered valid/ready output stage.
- Adds barrel shifts and a multi-cycle shift-and-add multiplier, which the combinational ALU lacks.
- Sits between the register-file read stage and writeback in the lab CPU datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), shift-amount bits taken from B[SHW-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and control presented.
- in_ready  output  1  block accepts an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- control  input  4  opcode.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- ovf  output  1  overflow flag.
- carry  output  1  carry flag.
- illegal  output  1  opcode unsupported.

Behaviour:
- Reset (async, reset_n low): state IDLE; out_valid, result, zero, ovf, carry, illegal all 0; multiplier registers cleared.
- Reset mid-multiply aborts the operation; no result is produced.
- Opcodes:
  - 0 ADD, 1 SUB, 2 XOR, 3 SLT (signed; result 1 or 0), 4 AND, 5 NAND, 6 NOR, 7 OR.
  - 8 SLL, 9 SRL, 10 SRA: shift amount is b[SHW-1:0].
  - 11 MUL: unsigned, low WIDTH bits.
  - 12-15 illegal.
- Accept: a transfer occurs when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Single-cycle ops (0-10, illegal): result, flags and out_valid register on the accept edge, giving 1-cycle latency. Back-to-back accepts are sustained at 1 op/cycle while out_ready is held high.
- MUL: IDLE -> MUL_BUSY on accept. Operands are latched and the iteration counter is set to WIDTH. One partial-product bit is processed per cycle. When the counter reaches 0, the block registers result and out_valid and returns to IDLE. Latency is WIDTH+1 cycles from accept to out_valid. in_ready is 0 throughout MUL_BUSY.
- Output hold: while out_valid && !out_ready, result and all flags are held stable. A single-cycle op cannot be accepted in that cycle, and a finishing MUL stalls in MUL_BUSY with the counter at 0.
- out_valid clears on out_ready unless a new result loads in the same cycle; a simultaneous consume and load gives the new result.
- Flags:
  - zero = (result==0) for every opcode, including illegal (result 0, so zero=1).
  - ADD: carry = unsigned carry-out of bit WIDTH-1; ovf = signed overflow.
  - SUB: computed as a + ~b + 1; carry = 1 when no borrow (a >= b unsigned); ovf = signed overflow.
  - MUL: ovf = 1 when the upper WIDTH bits of the full product are non-zero; carry = 0.
  - All other ops: ovf = carry = 0.
  - illegal = 1 only for opcodes 12-15, and only accompanying that result.
- Arithmetic wraps modulo 2^WIDTH. SRA replicates a[WIDTH-1]. A shift by 0 returns a.

Optional Feature:
- SEQ_ALU_MUL_EN defined: opcode 11 is implemented as specified, with the MUL_BUSY state and multiplier datapath.
- SEQ_ALU_MUL_EN undefined: no multiplier logic is built. Opcode 11 is treated as illegal (1-cycle, result 0, illegal=1), and in_ready depends only on output-stage occupancy.

Test Plan:
- Reset: hold reset_n=0 mid-stream -> all outputs 0 and in_ready=1 after release. Assert reset_n=0 during a MUL -> no out_valid appears after release.
- ADD, WIDTH=32: a=1, b=2 then b=4, b=8, out_ready=1 -> results 3, 5, 9 on consecutive cycles; each has out_valid, zero=0. Also a=32'hFFFFFFFF, b=1 -> result 0, zero=1, carry=1, ovf=0.
- SUB/SLT, WIDTH=32:
  - a=32'h7FFFFFFF, b=32'hFFFFFFFF SUB -> 32'h80000000, ovf=1, carry=0.
  - a=5, b=5 SUB -> 0, zero=1, carry=1.
  - SLT a=-1, b=1 -> 1.
- Shifts, WIDTH=32:
  - SRA a=32'h80000000, b=4 -> 32'hF8000000.
  - SRL same operands -> 32'h08000000.
  - SLL a=1, b=37 -> 32'h00000020 (only b[4:0] used).
- MUL, WIDTH=32: a=32'h10000, b=32'h10000 -> result 0, ovf=1, out_valid exactly 33 cycles after accept, in_ready=0 meanwhile. With macro undefined -> illegal=1 after 1 cycle.
- Backpressure: out_ready=0 for 5 cycles after an ADD of 1+2 -> result 3 held, in_ready=0. Then out_ready=1 with a queued op -> consume and new load in the same cycle, no bubble, no lost result.

Source files
------------

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes, barrel shifts and an optional
// shift-and-add multiplier (enabled by defining SEQ_ALU_MUL_EN).
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             carry,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;

  logic             accept;
  logic             sub_op;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;
  logic             op_illegal;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_carry;
  logic             load;
  logic [WIDTH-1:0] nxt_res;
  logic             nxt_ovf;
  logic             nxt_carry;
  logic             nxt_ill;

  assign accept = in_valid && in_ready;

  // SUB shares the adder as a + ~b + 1, so carry-out means "no borrow".
  assign sub_op = (control == OP_SUB);
  assign b_op   = sub_op ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_op};
  assign sh     = b[SHW-1:0];

  always_comb begin
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_carry = 1'b0;
    case (control)
      OP_ADD, OP_SUB: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_AND:  alu_res = a & b;
      OP_NAND: alu_res = ~(a & b);
      OP_NOR:  alu_res = ~(a | b);
      OP_OR:   alu_res = a | b;
      OP_SLL:  alu_res = a << sh;
      OP_SRL:  alu_res = a >> sh;
      OP_SRA:  alu_res = $signed(a) >>> sh;
      default: alu_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [SHW:0]       cnt;
  logic [WIDTH:0]     step_sum;

  assign op_illegal = (control >= 4'd12);
  assign is_mul     = (control == OP_MUL);
  assign mul_done   = (state == MUL_BUSY) && (cnt == '0) && (!out_valid || out_ready);

  // Upper half accumulates; the multiplier shifts out of the lower half.
  assign step_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !out_valid || out_ready;
        if (accept && is_mul) state_nxt = MUL_BUSY;
      end
      MUL_BUSY: begin
        if (mul_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod  <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else if (accept && is_mul) begin
      prod  <= {{WIDTH{1'b0}}, b};
      mcand <= a;
      cnt   <= (SHW+1)'(WIDTH);
    end else if ((state == MUL_BUSY) && (cnt != '0)) begin
      prod  <= {step_sum, prod[WIDTH-1:1]};
      cnt   <= cnt - 1'b1;
    end
  end

  always_comb begin
    load      = accept && !is_mul;
    nxt_res   = alu_res;
    nxt_ovf   = alu_ovf;
    nxt_carry = alu_carry;
    nxt_ill   = op_illegal;
    if (mul_done) begin
      load      = 1'b1;
      nxt_res   = prod[WIDTH-1:0];
      nxt_ovf   = |prod[2*WIDTH-1:WIDTH];
      nxt_carry = 1'b0;
      nxt_ill   = 1'b0;
    end
  end
`else
  assign op_illegal = (control >= 4'd11);
  assign in_ready   = !out_valid || out_ready;

  always_comb begin
    load      = accept;
    nxt_res   = alu_res;
    nxt_ovf   = alu_ovf;
    nxt_carry = alu_carry;
    nxt_ill   = op_illegal;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      carry     <= 1'b0;
      illegal   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= nxt_res;
      zero      <= (nxt_res == '0);
      ovf       <= nxt_ovf;
      carry     <= nxt_carry;
      illegal   <= nxt_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed steps followed by random traffic
// against an arithmetic reference model and an in-order result queue.
module tb_seq_alu;

  localparam int unsigned W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        c;
    logic        il;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   control = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         carry;
  logic         illegal;

  int total = 0;
  int bad   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .control(control), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .carry(carry), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [36:0] obs_vec();
    return {out_valid, result, zero, ovf, carry, illegal};
  endfunction

  function automatic logic [36:0] ev(input logic [31:0] r, input logic z, input logic o,
                                     input logic c, input logic il);
    return {1'b1, r, z, o, c, il};
  endfunction

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    exp_t        e;
    longint      sx;
    longint      sy;
    longint      r;
    logic [63:0] p;
    int unsigned s;
    e  = '0;
    sx = $signed(x);
    sy = $signed(y);
    s  = int'(y[4:0]);
    p  = '0;
    case (op)
      4'd0: begin
        e.res = x + y;
        e.c   = ({32'd0, x} + {32'd0, y}) >= 64'h1_0000_0000;
        r     = sx + sy;
        e.o   = (r > MAXS) || (r < MINS);
      end
      4'd1: begin
        e.res = x - y;
        e.c   = (x >= y);
        r     = sx - sy;
        e.o   = (r > MAXS) || (r < MINS);
      end
      4'd2:  e.res = x ^ y;
      4'd3:  e.res = (sx < sy) ? 32'd1 : 32'd0;
      4'd4:  e.res = x & y;
      4'd5:  e.res = ~(x & y);
      4'd6:  e.res = ~(x | y);
      4'd7:  e.res = x | y;
      4'd8:  e.res = x << s;
      4'd9:  e.res = x >> s;
      4'd10: e.res = 32'(sx >>> s);
`ifdef SEQ_ALU_MUL_EN
      4'd11: begin
        p     = {32'd0, x} * {32'd0, y};
        e.res = p[31:0];
        e.o   = (p[63:32] != 32'd0);
      end
`endif
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    control  = op;
  endtask

  task automatic op1(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [3:0] op, input logic [31:0] r, input logic z,
                     input logic o, input logic c, input logic il);
    @(negedge clk);
    drive(x, y, op);
    #1 check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check(tag, 64'(obs_vec()), 64'(ev(r, z, o, c, il)));
  endtask

  exp_t        q[$];
  logic        pv, pr, pir, pov;
  logic [31:0] px, py;
  logic [3:0]  pop;
  int          n;
  logic        seen;

  initial begin
    // Reset values while held, then ready after release
    reset_n   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'(obs_vec()), 64'd0);
    reset_n = 1'b1;
    #1 check("reset_rdy", 64'(in_ready), 64'd1);

    // Back-to-back ADDs at one per cycle
    @(negedge clk);
    drive(32'd1, 32'd2, 4'd0);
    #1 check("b2b_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("add_1_2", 64'(obs_vec()), 64'(ev(32'd3, 1'b0, 1'b0, 1'b0, 1'b0)));
    b = 32'd4;
    @(negedge clk);
    check("add_1_4", 64'(obs_vec()), 64'(ev(32'd5, 1'b0, 1'b0, 1'b0, 1'b0)));
    b = 32'd8;
    @(negedge clk);
    check("add_1_8", 64'(obs_vec()), 64'(ev(32'd9, 1'b0, 1'b0, 1'b0, 1'b0)));
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_drain", 64'(out_valid), 64'd0);

    op1("add_wrap", 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    op1("sub_ovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    op1("sub_eq", 32'd5, 32'd5, 4'd1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    op1("slt_neg", 32'hFFFF_FFFF, 32'd1, 4'd3, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    op1("sra", 32'h8000_0000, 32'd4, 4'd10, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    op1("srl", 32'h8000_0000, 32'd4, 4'd9, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    op1("sll_mask", 32'd1, 32'd37, 4'd8, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0);
    op1("shift0", 32'h1234_5678, 32'd32, 4'd10, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    op1("illegal13", 32'd7, 32'd9, 4'd13, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Multiplier latency, or illegal when not built
    @(negedge clk);
    drive(32'h0001_0000, 32'h0001_0000, 4'd11);
    #1 check("mul_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    n = 1;
    while (!out_valid && n < 60) begin
      check("mul_busy_rdy", 64'(in_ready), 64'd0);
      @(negedge clk);
      n++;
    end
    check("mul_latency", 64'(n), 64'd33);
    check("mul_out", 64'(obs_vec()), 64'(ev(32'd0, 1'b1, 1'b1, 1'b0, 1'b0)));
`else
    check("mul_illegal", 64'(obs_vec()), 64'(ev(32'd0, 1'b1, 1'b0, 1'b0, 1'b1)));
`endif
    @(negedge clk);

    // Backpressure: hold, then consume and load on the same edge
    out_ready = 1'b0;
    drive(32'd1, 32'd2, 4'd0);
    #1 check("bp_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(32'd5, 32'd5, 4'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold", 64'(obs_vec()), 64'(ev(32'd3, 1'b0, 1'b0, 1'b0, 1'b0)));
      check("bp_stall_rdy", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    check("bp_hold_end", 64'(obs_vec()), 64'(ev(32'd3, 1'b0, 1'b0, 1'b0, 1'b0)));
    out_ready = 1'b1;
    #1 check("bp_release_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next", 64'(obs_vec()), 64'(ev(32'd0, 1'b1, 1'b0, 1'b1, 1'b0)));
    @(negedge clk);
    check("bp_drain", 64'(out_valid), 64'd0);

    // Asynchronous reset with a result pending
    out_ready = 1'b0;
    op1("pre_reset", 32'd7, 32'd8, 4'd7, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1 check("midreset_outs", 64'(obs_vec()), 64'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1 check("midreset_rdy", 64'(in_ready), 64'd1);

`ifdef SEQ_ALU_MUL_EN
    // Reset during a multiply must discard it
    @(negedge clk);
    drive(32'd3, 32'd5, 4'd11);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("mul_abort_rdy", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mul_abort", 64'(seen), 64'd0);
`endif

    // Random traffic with random backpressure, then drain
    pv = 1'b0; pr = 1'b0; pir = 1'b0; pov = 1'b0;
    px = '0; py = '0; pop = '0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      if (pov && pr && q.size() > 0) void'(q.pop_front());
      if (pv && pir) q.push_back(model(px, py, pop));
      if (q.size() == 0) check("rnd_idle", 64'(out_valid), 64'd0);
      else if (out_valid) check("rnd_out", 64'(obs_vec()), 64'({1'b1, q[0]}));
      if (cyc < 600) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        a         = rnd_operand();
        b         = rnd_operand();
        control   = 4'($urandom_range(0, 15));
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      pv  = in_valid;
      pr  = out_ready;
      pir = in_ready;
      pov = out_valid;
      px  = a;
      py  = b;
      pop = control;
    end
    check("rnd_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
